// File: rtl/avalon_rsa_dma.sv
// avalon_rsa_dma: multi-block DMA front end for a byte-loaded RSA core.
// Software programs SRC_BASE, DST_BASE and NUM_BLOCKS through a 32-bit CSR
// slave and writes CTRL.start. The block reads N and E once, then for each
// message block it reads the message, byte-loads it, starts the core, waits
// for ready, unloads the result and writes it back over Avalon-MM.
// Ports:
//   clk, reset            single clock, asynchronous active-high reset
//   avs_s0_*              CSR slave (0 CTRL/STATUS, 1 SRC, 2 DST, 3 NUM_BLOCKS)
//   avm_m0_*              Avalon-MM master, DATA_W data, ADDR_W byte address
//   core_*                byte-wide load/unload/start/ready interface to core
//   irq                   done & irq_en
module avalon_rsa_dma #(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16,
  localparam int BYTES = DATA_W / 8,
  localparam int CA_W  = $clog2(BYTES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        avs_s0_address,
  input  logic              avs_s0_read,
  input  logic              avs_s0_write,
  input  logic [31:0]       avs_s0_writedata,
  output logic [31:0]       avs_s0_readdata,
  output logic              avs_s0_waitrequest,
  output logic [ADDR_W-1:0] avm_m0_address,
  output logic              avm_m0_read,
  output logic              avm_m0_write,
  input  logic              avm_m0_waitrequest,
  input  logic              avm_m0_readdatavalid,
  input  logic [DATA_W-1:0] avm_m0_readdata,
  output logic [DATA_W-1:0] avm_m0_writedata,
  output logic              core_we,
  output logic              core_oe,
  output logic              core_start,
  output logic [1:0]        core_reg_sel,
  output logic [CA_W-1:0]   core_addr,
  output logic [7:0]        core_data_i,
  input  logic [7:0]        core_data_o,
  input  logic              core_ready,
  output logic              irq
);

  localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(BYTES);
  localparam logic [CA_W-1:0]   LAST_ADDR = CA_W'(BYTES - 1);
  localparam logic [CA_W:0]     U_LAST    = (CA_W+1)'(BYTES - 1);
  localparam logic [CA_W:0]     U_END     = (CA_W+1)'(BYTES);

  typedef enum logic [3:0] {
    IDLE, KEY_RD, KEY_LD, MSG_RD, MSG_LD, START, CALC, UNLOAD, WR, DONE
  } state_t;

  state_t            state;
  logic              busy, done, irq_en;
  logic [31:0]       src_base, dst_base;
  logic [CNT_W-1:0]  num_blocks, blk_cnt;
  logic [ADDR_W-1:0] rd_ptr, wr_ptr;   // next read / write address
  logic              key_sel;          // 0 = loading N, 1 = loading E
  logic              calc_hold;        // masks core_ready right after start
  logic [DATA_W-1:0] word;             // remaining bytes of the word being loaded
  logic [CA_W:0]     ucnt;             // unload cycle index 0..BYTES
  logic              start_req;

  assign avs_s0_waitrequest = 1'b0;
  assign irq = done & irq_en;
  assign start_req = avs_s0_write && (avs_s0_address == 2'd0) &&
                     avs_s0_writedata[0] && !busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      busy             <= 1'b0;
      done             <= 1'b0;
      irq_en           <= 1'b0;
      src_base         <= '0;
      dst_base         <= '0;
      num_blocks       <= '0;
      blk_cnt          <= '0;
      rd_ptr           <= '0;
      wr_ptr           <= '0;
      key_sel          <= 1'b0;
      calc_hold        <= 1'b0;
      word             <= '0;
      ucnt             <= '0;
      avs_s0_readdata  <= '0;
      avm_m0_address   <= '0;
      avm_m0_read      <= 1'b0;
      avm_m0_write     <= 1'b0;
      avm_m0_writedata <= '0;
      core_we          <= 1'b0;
      core_oe          <= 1'b0;
      core_start       <= 1'b0;
      core_reg_sel     <= '0;
      core_addr        <= '0;
      core_data_i      <= '0;
    end else begin
      if (avs_s0_read) begin
        case (avs_s0_address)
          2'd0:    avs_s0_readdata <= {29'b0, irq_en, done, busy};
          2'd1:    avs_s0_readdata <= src_base;
          2'd2:    avs_s0_readdata <= dst_base;
          default: avs_s0_readdata <= 32'(num_blocks);
        endcase
      end
      if (avs_s0_write) begin
        case (avs_s0_address)
          2'd0: begin
            irq_en <= avs_s0_writedata[2];
            if (avs_s0_writedata[1]) done <= 1'b0;
          end
          2'd1:    if (!busy) src_base <= avs_s0_writedata;
          2'd2:    if (!busy) dst_base <= avs_s0_writedata;
          default: if (!busy) num_blocks <= avs_s0_writedata[CNT_W-1:0];
        endcase
      end

      case (state)
        IDLE: if (start_req) begin
          busy    <= 1'b1;
          blk_cnt <= '0;
          key_sel <= 1'b0;
          wr_ptr  <= ADDR_W'(dst_base);
          if (num_blocks == '0) begin
            state <= DONE;
          end else begin
            state          <= KEY_RD;
            avm_m0_read    <= 1'b1;
            avm_m0_address <= ADDR_W'(src_base);
            rd_ptr         <= ADDR_W'(src_base) + STEP;
          end
        end
        KEY_RD, MSG_RD: begin
          if (avm_m0_read && !avm_m0_waitrequest) avm_m0_read <= 1'b0;
          // Data can only belong to our read once the request has been accepted.
          if (avm_m0_readdatavalid && !avm_m0_read) begin
            core_we      <= 1'b1;
            core_addr    <= '0;
            core_data_i  <= avm_m0_readdata[7:0];
            word         <= avm_m0_readdata >> 8;
            core_reg_sel <= (state == MSG_RD) ? 2'b01 : (key_sel ? 2'b11 : 2'b10);
            state        <= (state == KEY_RD) ? KEY_LD : MSG_LD;
          end
        end
        KEY_LD, MSG_LD: begin
          if (core_addr == LAST_ADDR) begin
            core_we <= 1'b0;
            if (state == MSG_LD) begin
              state      <= START;
              core_start <= 1'b1;
            end else begin
              // Reads are sequential from SRC_BASE: N, E, then the messages.
              key_sel        <= 1'b1;
              state          <= key_sel ? MSG_RD : KEY_RD;
              avm_m0_read    <= 1'b1;
              avm_m0_address <= rd_ptr;
              rd_ptr         <= rd_ptr + STEP;
            end
          end else begin
            core_addr   <= core_addr + 1'b1;
            core_data_i <= word[7:0];
            word        <= word >> 8;
          end
        end
        START: begin
          core_start <= 1'b0;
          calc_hold  <= 1'b1;
          state      <= CALC;
        end
        CALC: begin
          if (calc_hold) begin
            calc_hold <= 1'b0;
          end else if (core_ready) begin
            state     <= UNLOAD;
            core_oe   <= 1'b1;
            core_addr <= '0;
            ucnt      <= '0;
          end
        end
        UNLOAD: begin
          ucnt <= ucnt + 1'b1;
          // One-cycle read latency: byte k arrives while addr k+1 is presented.
          if (ucnt != '0)
            avm_m0_writedata <= {core_data_o, avm_m0_writedata[DATA_W-1:8]};
          if (ucnt == U_LAST) core_oe <= 1'b0;
          else if (core_oe)   core_addr <= core_addr + 1'b1;
          if (ucnt == U_END) begin
            state          <= WR;
            avm_m0_write   <= 1'b1;
            avm_m0_address <= wr_ptr;
          end
        end
        WR: if (!avm_m0_waitrequest) begin
          avm_m0_write <= 1'b0;
          wr_ptr       <= wr_ptr + STEP;
          blk_cnt      <= blk_cnt + 1'b1;
          if (blk_cnt == num_blocks - 1'b1) begin
            state <= DONE;
          end else begin
            state          <= MSG_RD;
            avm_m0_read    <= 1'b1;
            avm_m0_address <= rd_ptr;
            rd_ptr         <= rd_ptr + STEP;
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
